btfly4_stream_ctrl: RTL
=======================

BTFLY4_STREAM_CTRL -- requirements
Module: btfly4_stream_ctrl

Interface
REQ-001 SHALL have parameter NB_INPUT, default 8, meaning signed width of each input real/imag component.
REQ-002 SHALL have parameter NB_OUTPUT, default 9, meaning signed width of each output real/imag component.
REQ-003 SHALL have port i_clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_clear  input  1  synchronous abort of the current group.
REQ-006 SHALL have port i_valid  input  1  input sample valid.
REQ-007 SHALL have port o_ready  output  1  block accepts an input sample this cycle.
REQ-008 SHALL have ports i_data_r, i_data_i  input  NB_INPUT each  signed input sample, real and imaginary parts.
REQ-009 SHALL have port o_valid  output  1  output sample valid.
REQ-010 SHALL have port i_ready  input  1  downstream accepts the output sample.
REQ-011 SHALL have ports o_data_r, o_data_i  output  NB_OUTPUT each  signed output sample, real and imaginary parts.
REQ-012 SHALL have port o_first  output  1  marks output index 0 of a group.
REQ-013 SHALL have port o_last  output  1  marks output index 3 of a group.
REQ-014 SHALL have port o_busy  output  1  high whenever the state is not LOAD or the load count is nonzero.

Function
REQ-015 SHALL implement a three-state FSM:
- LOAD: collect 4 samples.
- CALC: compute for one cycle.
- DRAIN: emit 4 samples.
REQ-016 SHALL drive o_ready = 1 only in LOAD and only while i_reset = 0.
REQ-017 SHALL capture the input into slot x[k], k = 2-bit load counter, on each cycle with i_valid & o_ready; then increment k.
REQ-018 SHALL move to CALC on the acceptance at k = 3; k SHALL wrap to 0.
REQ-019 SHALL in CALC register, for the real and imaginary parts separately: y0 = x0+x2, y2 = x0-x2, y1 = x1+x3, y3 = x1-x3.
- Operands sign-extended to NB_OUTPUT before the add.
- Results are full precision; no rounding or saturation.
REQ-020 SHALL move from CALC to DRAIN unconditionally after one cycle.
REQ-021 SHALL hold o_valid = 1 throughout DRAIN.
REQ-022 SHALL present y[j] on o_data_r and o_data_i in DRAIN, j = 2-bit drain counter.
REQ-023 SHALL advance j only on a cycle with o_valid & i_ready.
REQ-024 SHALL hold o_data_r, o_data_i, o_first and o_last stable while o_valid = 1 and i_ready = 0.
REQ-025 SHALL drive o_first = (j == 0) and o_last = (j == 3), both qualified by o_valid.
REQ-026 SHALL return to LOAD after the handshake at j = 3, with j wrapping to 0; o_ready SHALL be 1 in the next cycle.
REQ-027 SHALL have latency: acceptance of the 4th input in cycle t gives o_valid = 1 first in cycle t+2.
REQ-028 SHALL have minimum group period 9 cycles with i_valid and i_ready held high (4 LOAD + 1 CALC + 4 DRAIN).
REQ-029 SHALL handle i_clear = 1 in any state as follows:
- Next state LOAD; k = 0; j = 0.
- o_valid = 0 and o_ready = 1 in the next cycle.
- Partial input data is discarded.
- Any handshake in the same cycle is ignored.
REQ-030 SHALL not accept input while in CALC or DRAIN; i_valid there has no effect.

Reset
REQ-031 SHALL, while i_reset = 1 at a rising edge, set state = LOAD, k = 0, j = 0, all x and y registers = 0.
REQ-032 SHALL drive o_valid = 0, o_ready = 0, o_first = 0, o_last = 0, o_busy = 0 and o_data = 0 during reset.
REQ-033 SHALL give i_reset priority over i_clear and over all handshakes.
REQ-034 SHALL on reset mid-group discard the group, with no partial output afterwards.

Structure
REQ-035 SHALL place the FSM state encoding (LOAD = 0, CALC = 1, DRAIN = 2) and the group size constant 4 in the shared FFT package.
REQ-036 SHALL instantiate one btfly_4 sub-module, NB_INPUT/NB_OUTPUT passed through.
- It is fed from x0..x3 and produces y0..y3.
- Its outputs are registered in CALC.
REQ-037 SHALL require NB_OUTPUT >= NB_INPUT + 1; an elaboration check SHALL fail otherwise.

Verification
REQ-038 SHALL cover basic transform: inputs (1,0),(2,0),(3,0),(4,0) with i_ready = 1 -> outputs (4,0),(6,0),(-2,0),(-2,0) at t+2..t+5; o_first with the 1st output, o_last with the 4th.
REQ-039 SHALL cover extremes: all four inputs (-128,127), NB 8/9 -> y0 = y1 = (-256,254), y2 = y3 = (0,0), no overflow.
REQ-040 SHALL cover backpressure: i_ready low for 3 cycles at j = 1 -> y1 held constant, o_valid stays 1, o_ready stays 0, then the sequence completes in order.
REQ-041 SHALL cover input gaps: i_valid toggling 1,0,1,0... -> only handshaked samples are stored; outputs match a gap-free run.
REQ-042 SHALL cover clear: i_clear after 2 loaded samples, then a fresh group (5,5),(1,1),(5,5),(1,1) -> outputs (10,10),(2,2),(0,0),(0,0); no stale data.
REQ-043 SHALL cover reset: i_reset asserted in DRAIN at j = 2 -> next cycle o_valid = 0, o_ready = 0; the following cycle o_ready = 1, o_busy = 0.

Source files
------------

// File: rtl/btfly4_stream_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btfly4_stream_ctrl_pkg
//  Description : Shared FFT definitions for the radix-4 butterfly stream
//                controller. Holds the controller state encoding, the group
//                size and the width of the in-group sample index.
//  Revision    : 1.0  initial release
// ============================================================================
package btfly4_stream_ctrl_pkg;

    // Samples per butterfly group: four are loaded, four are drained.
    localparam int C_GROUP_SIZE = 4;

    // Width of the load / drain sample index.
    localparam int C_IDX_W = 2;

    // Last index of a group, as an index-width value.
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_GROUP_SIZE - 1);

    // Controller states.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CALC  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage : btfly4_stream_ctrl_pkg
`default_nettype wire

// File: rtl/btfly4_stream_ctrl_btfly_4.sv
`default_nettype none
// ============================================================================
//  Module      : btfly_4
//  Description : Combinational two-pair butterfly on complex samples.
//                y0 = x0 + x2, y2 = x0 - x2, y1 = x1 + x3, y3 = x1 - x3,
//                computed separately on real and imaginary parts. Operands
//                are sign-extended to NB_OUTPUT first, so results are exact.
//  Revision    : 1.0  initial release
// ============================================================================
module btfly_4 #(
    parameter int NB_INPUT  = 8,
    parameter int NB_OUTPUT = 9
) (
    input  logic signed [NB_INPUT-1:0]  i_x0_r,
    input  logic signed [NB_INPUT-1:0]  i_x0_i,
    input  logic signed [NB_INPUT-1:0]  i_x1_r,
    input  logic signed [NB_INPUT-1:0]  i_x1_i,
    input  logic signed [NB_INPUT-1:0]  i_x2_r,
    input  logic signed [NB_INPUT-1:0]  i_x2_i,
    input  logic signed [NB_INPUT-1:0]  i_x3_r,
    input  logic signed [NB_INPUT-1:0]  i_x3_i,
    output logic signed [NB_OUTPUT-1:0] o_y0_r,
    output logic signed [NB_OUTPUT-1:0] o_y0_i,
    output logic signed [NB_OUTPUT-1:0] o_y1_r,
    output logic signed [NB_OUTPUT-1:0] o_y1_i,
    output logic signed [NB_OUTPUT-1:0] o_y2_r,
    output logic signed [NB_OUTPUT-1:0] o_y2_i,
    output logic signed [NB_OUTPUT-1:0] o_y3_r,
    output logic signed [NB_OUTPUT-1:0] o_y3_i
);

    logic signed [NB_OUTPUT-1:0] w_x0_r;
    logic signed [NB_OUTPUT-1:0] w_x0_i;
    logic signed [NB_OUTPUT-1:0] w_x1_r;
    logic signed [NB_OUTPUT-1:0] w_x1_i;
    logic signed [NB_OUTPUT-1:0] w_x2_r;
    logic signed [NB_OUTPUT-1:0] w_x2_i;
    logic signed [NB_OUTPUT-1:0] w_x3_r;
    logic signed [NB_OUTPUT-1:0] w_x3_i;

    // Sign-extend every operand to the output width before adding.
    assign w_x0_r = NB_OUTPUT'(i_x0_r);
    assign w_x0_i = NB_OUTPUT'(i_x0_i);
    assign w_x1_r = NB_OUTPUT'(i_x1_r);
    assign w_x1_i = NB_OUTPUT'(i_x1_i);
    assign w_x2_r = NB_OUTPUT'(i_x2_r);
    assign w_x2_i = NB_OUTPUT'(i_x2_i);
    assign w_x3_r = NB_OUTPUT'(i_x3_r);
    assign w_x3_i = NB_OUTPUT'(i_x3_i);

    // Even pair (x0, x2) feeds y0/y2; odd pair (x1, x3) feeds y1/y3.
    assign o_y0_r = w_x0_r + w_x2_r;
    assign o_y0_i = w_x0_i + w_x2_i;
    assign o_y2_r = w_x0_r - w_x2_r;
    assign o_y2_i = w_x0_i - w_x2_i;
    assign o_y1_r = w_x1_r + w_x3_r;
    assign o_y1_i = w_x1_i + w_x3_i;
    assign o_y3_r = w_x1_r - w_x3_r;
    assign o_y3_i = w_x1_i - w_x3_i;

endmodule : btfly_4
`default_nettype wire

// File: rtl/btfly4_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : btfly4_stream_ctrl
//  Description : Streaming radix-4 butterfly controller. Loads a group of
//                four complex samples over a valid/ready input, computes the
//                butterfly in one cycle, then drains four results over a
//                valid/ready output with first/last group markers.
//  Revision    : 1.0  initial release
// ============================================================================
module btfly4_stream_ctrl
    import btfly4_stream_ctrl_pkg::*;
#(
    parameter int NB_INPUT  = 8,
    parameter int NB_OUTPUT = 9
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_clear,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic signed [NB_INPUT-1:0]  i_data_r,
    input  logic signed [NB_INPUT-1:0]  i_data_i,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [NB_OUTPUT-1:0] o_data_r,
    output logic signed [NB_OUTPUT-1:0] o_data_i,
    output logic                        o_first,
    output logic                        o_last,
    output logic                        o_busy
);

    // The butterfly grows by one bit; anything narrower would overflow.
    generate
        if (NB_OUTPUT < NB_INPUT + 1) begin : g_width_check
            $error("btfly4_stream_ctrl: NB_OUTPUT must be at least NB_INPUT + 1");
        end
    endgenerate

    state_e                      state_q, state_d;
    logic [C_IDX_W-1:0]          k_q, k_d;
    logic [C_IDX_W-1:0]          j_q, j_d;
    logic signed [NB_INPUT-1:0]  x_r_q [C_GROUP_SIZE];
    logic signed [NB_INPUT-1:0]  x_i_q [C_GROUP_SIZE];
    logic signed [NB_INPUT-1:0]  x_r_d [C_GROUP_SIZE];
    logic signed [NB_INPUT-1:0]  x_i_d [C_GROUP_SIZE];
    logic signed [NB_OUTPUT-1:0] y_r_q [C_GROUP_SIZE];
    logic signed [NB_OUTPUT-1:0] y_i_q [C_GROUP_SIZE];
    logic signed [NB_OUTPUT-1:0] y_r_d [C_GROUP_SIZE];
    logic signed [NB_OUTPUT-1:0] y_i_d [C_GROUP_SIZE];

    logic signed [NB_OUTPUT-1:0] w_bf_r [C_GROUP_SIZE];
    logic signed [NB_OUTPUT-1:0] w_bf_i [C_GROUP_SIZE];

    logic w_ready;
    logic w_valid;

    btfly_4 #(
        .NB_INPUT  (NB_INPUT),
        .NB_OUTPUT (NB_OUTPUT)
    ) u_btfly_4 (
        .i_x0_r (x_r_q[0]),
        .i_x0_i (x_i_q[0]),
        .i_x1_r (x_r_q[1]),
        .i_x1_i (x_i_q[1]),
        .i_x2_r (x_r_q[2]),
        .i_x2_i (x_i_q[2]),
        .i_x3_r (x_r_q[3]),
        .i_x3_i (x_i_q[3]),
        .o_y0_r (w_bf_r[0]),
        .o_y0_i (w_bf_i[0]),
        .o_y1_r (w_bf_r[1]),
        .o_y1_i (w_bf_i[1]),
        .o_y2_r (w_bf_r[2]),
        .o_y2_i (w_bf_i[2]),
        .o_y3_r (w_bf_r[3]),
        .o_y3_i (w_bf_i[3])
    );

    // Handshake qualifiers; reset forces both low so nothing moves during it.
    assign w_ready = (state_q == ST_LOAD)  && !i_reset;
    assign w_valid = (state_q == ST_DRAIN) && !i_reset;

    // Next-state, slot capture, butterfly register and index logic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        x_r_d   = x_r_q;
        x_i_d   = x_i_q;
        y_r_d   = y_r_q;
        y_i_d   = y_i_q;

        if (i_clear) begin
            // Abort: restart loading; stale slots are overwritten later.
            state_d = ST_LOAD;
            k_d     = '0;
            j_d     = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (i_valid && w_ready) begin
                        x_r_d[k_q] = i_data_r;
                        x_i_d[k_q] = i_data_i;
                        k_d        = k_q + 1'b1;
                        if (k_q == C_LAST_IDX) begin
                            state_d = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    y_r_d   = w_bf_r;
                    y_i_d   = w_bf_i;
                    state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_valid && i_ready) begin
                        j_d = j_q + 1'b1;
                        if (j_q == C_LAST_IDX) begin
                            state_d = ST_LOAD;
                        end
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                    k_d     = '0;
                    j_d     = '0;
                end
            endcase
        end
    end

    // State, index and data registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_LOAD;
            k_q     <= '0;
            j_q     <= '0;
            for (int s = 0; s < C_GROUP_SIZE; s++) begin
                x_r_q[s] <= '0;
                x_i_q[s] <= '0;
                y_r_q[s] <= '0;
                y_i_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            x_r_q   <= x_r_d;
            x_i_q   <= x_i_d;
            y_r_q   <= y_r_d;
            y_i_q   <= y_i_d;
        end
    end

    // Outputs are qualified by valid, which also zeroes them during reset.
    assign o_ready  = w_ready;
    assign o_valid  = w_valid;
    assign o_data_r = w_valid ? y_r_q[j_q] : '0;
    assign o_data_i = w_valid ? y_i_q[j_q] : '0;
    assign o_first  = w_valid && (j_q == '0);
    assign o_last   = w_valid && (j_q == C_LAST_IDX);
    assign o_busy   = !i_reset && ((state_q != ST_LOAD) || (k_q != '0));

endmodule : btfly4_stream_ctrl
`default_nettype wire
